// File: rtl/reg_write_demux.sv
// reg_write_demux: register-file write demux, one-hot load enables plus data bus.
// Single-word writes, plus two-beat even/odd double-word writes with a Ready handshake.
//
// Ports:
//   Clk   - clock, rising edge
//   Clr   - synchronous active-low reset
//   WrEn  - write request, accepted only while Ready=1
//   Dw    - double-word request (even beat, then odd beat)
//   Addr  - target register (bit 0 ignored for Dw)
//   DataA - single-write data, or the even-beat data
//   DataB - odd-beat data
//   Ready - request can be accepted this cycle (registered)
//   Ld    - registered one-hot load enables, one cycle wide
//   Out   - write data broadcast to all registers
//
// Optional: define G0_PROTECT_EN to keep Ld[0] (%g0) permanently low.
module reg_write_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     WrEn,
  input  logic                     Dw,
  input  logic [ADDR_W-1:0]        Addr,
  input  logic [DATA_W-1:0]        DataA,
  input  logic [DATA_W-1:0]        DataB,
  output logic                     Ready,
  output logic [(1<<ADDR_W)-1:0]   Ld,
  output logic [DATA_W-1:0]        Out
);

  localparam int LD_W = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  state_t              state_q, state_n;
  logic [LD_W-1:0]     ld_q, ld_n;
  logic [DATA_W-1:0]   out_q, out_n;
  logic                rdy_q, rdy_n;
  logic [ADDR_W-1:0]   odd_q, odd_n;
  logic [DATA_W-1:0]   datab_q, datab_n;

  function automatic logic [LD_W-1:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    logic [LD_W-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_n = state_q;
    ld_n    = '0;
    out_n   = out_q;
    rdy_n   = rdy_q;
    odd_n   = odd_q;
    datab_n = datab_q;
    unique case (state_q)
      IDLE: begin
        rdy_n = 1'b1;
        if (WrEn) begin
          out_n = DataA;
          if (Dw) begin
            ld_n    = onehot({Addr[ADDR_W-1:1], 1'b0});
            odd_n   = {Addr[ADDR_W-1:1], 1'b1};
            datab_n = DataB;
            rdy_n   = 1'b0;
            state_n = SECOND;
          end else begin
            ld_n = onehot(Addr);
          end
        end
      end
      SECOND: begin
        // Odd beat goes out regardless of WrEn; Ready was low.
        ld_n    = onehot(odd_q);
        out_n   = datab_q;
        rdy_n   = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
      end
    endcase
`ifdef G0_PROTECT_EN
    // %g0 is hardwired zero; the slot and data bus still update.
    ld_n[0] = 1'b0;
`else
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= IDLE;
      ld_q    <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b1;
      odd_q   <= '0;
      datab_q <= '0;
    end else begin
      state_q <= state_n;
      ld_q    <= ld_n;
      out_q   <= out_n;
      rdy_q   <= rdy_n;
      odd_q   <= odd_n;
      datab_q <= datab_n;
    end
  end

  assign Ld    = ld_q;
  assign Out   = out_q;
  assign Ready = rdy_q;

endmodule

// File: doc/reg_write_demux.md
Name: reg_write_demux

Overview:
- Write-side counterpart of the 32-input, 32-bit register read multiplexer (5-bit select).
- Takes one write request (5-bit address plus data) and produces a registered one-hot load-enable vector `Ld[31:0]` with the data broadcast on `Out`. These drive the 32 register load inputs of the SPARC register file.
- Supports single-word writes and two-beat double-word writes (even/odd register pair, as for LDD), sequenced by a small FSM with a `Ready` handshake.

Parameters:
- DATA_W, 32, width of write data and of `Out`.
- ADDR_W, 5, register address width; `Ld` width is 2**ADDR_W.

Ports:
- Clk    in   1       system clock, rising edge.
- Clr    in   1       synchronous, active-low reset.
- WrEn   in   1       write request; accepted only at an edge where `Ready`=1.
- Dw     in   1       double-word request (two beats); qualified by `WrEn`.
- Addr   in   ADDR_W  target register; for `Dw`, bit 0 is ignored.
- DataA  in   DATA_W  data for a single write or the even (first) beat.
- DataB  in   DATA_W  data for the odd (second) beat; ignored when `Dw`=0.
- Ready  out  1       block can accept a request this cycle.
- Ld     out  2**ADDR_W  one-hot register load enables, one cycle wide, or all zero.
- Out    out  DATA_W  write data bus to all registers.

Behaviour:
- Clock and reset: one clock `Clk`. Reset is synchronous, active-low on `Clr`, sampled at the rising edge.
- Reset values: `Ld`=0, `Out`=0, `Ready`=1, state IDLE, internal address/DataB holding registers=0. Reset overrides any request in flight, including mid double-word: the second beat is dropped.
- States: IDLE, SECOND.
- IDLE, edge with `WrEn`=1 and `Dw`=0:
  - Next cycle: `Ld`=onehot(`Addr`), `Out`=`DataA`.
  - Stays IDLE; `Ready` stays 1, so back-to-back single writes run at one per clock.
- IDLE, edge with `WrEn`=1 and `Dw`=1:
  - Next cycle: `Ld`=onehot({`Addr`[4:1],0}), `Out`=`DataA`, `Ready`=0.
  - Latches {`Addr`[4:1],1} and `DataB`; moves to SECOND.
- SECOND, next edge (unconditional):
  - `Ld`=onehot(latched odd address), `Out`=latched `DataB`, `Ready`=1.
  - Returns to IDLE. `WrEn` sampled at this edge is ignored because `Ready` was 0.
- No accepted request: `Ld`=0 next cycle; `Out` holds its last value.
- Latency: request edge n → load pulse during cycle n+1. Double-word second pulse during cycle n+2.
- `Ld` is never multi-hot. `Ld` pulse width is exactly one clock.
- Address 31 with `Dw`: beats go to 30 then 31. No wrap past 31.
- `Ready` is registered, never combinational from inputs.

Optional Feature:
- Macro: `G0_PROTECT_EN`.
- Defined:
  - `Ld`[0] is forced 0 at all times, so %g0 is never written.
  - A write to address 0 still consumes its slot and updates `Out`.
  - `Dw` to 0/1: first beat produces `Ld`=0, second beat writes register 1.
- Undefined: all 2**ADDR_W load enables are reachable, including `Ld`[0].

Test Plan:
- Reset: hold `Clr`=0 two cycles with `WrEn`=1, `Addr`=5 → `Ld`=0, `Out`=0, `Ready`=1 throughout. After release, first idle cycle still `Ld`=0.
- Sweep: `Addr`=0..31, one write per clock, `DataA`=1<<`Addr`:
  - Each following cycle `Ld`=1<<`Addr` and `Out`=1<<`Addr`. The sweep covers every onehot index.
  - With `G0_PROTECT_EN`, the `Addr`=0 cycle shows `Ld`=0 while `Out`=00000001.
- Double word: `Dw`=1, `Addr`=7, `DataA`=AAAA0000, `DataB`=0000BBBB.
  - Cycle n+1: `Ld`=00000040, `Out`=AAAA0000, `Ready`=0.
  - Cycle n+2: `Ld`=00000080, `Out`=0000BBBB, `Ready`=1.
- Blocked request: assert `WrEn` (`Addr`=3) during the `Ready`=0 cycle of a double-word → no `Ld`[3] pulse. Re-asserting at the next edge gives `Ld`=00000008 one cycle later.
- Mid-operation reset: `Clr`=0 at the SECOND edge of `Dw` to address 30 → `Ld`=0 next cycle (no pulse on bit 31), `Ready`=1, state IDLE.
- Idle hold: after a write of 12345678 to `Addr`=9, drive `WrEn`=0 for 5 cycles → `Ld`=0 and `Out` stays 12345678.
